mem_responder: RTL and testbench

Memory-side responder for the processor's READ/WRITE memory interface. It sits between the control unit and data path on one side and a word-addressed storage array on the other. It accepts level-held read and write requests, inserts a configurable number of wait states, and commits writes or returns read data. It signals each completion with a one-cycle READY pulse and flags malformed requests with ERR.

---
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_responder.sv | 179 +++++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between a requester and mem_responder
//
// Purpose: carries the level-held READ/WRITE request, its address and write data,
// and the responder's READY/ERR/BUSY status and registered read data.
// Ports (signals):
//   READ, WRITE     requester -> responder, level, held until READY
//   ADDR            requester -> responder, word address
//   DATA_IN         requester -> responder, write data
//   DATA_OUT        responder -> requester, read data, holds between reads
//   READY, ERR      responder -> requester, one-cycle completion / error pulses
//   BUSY            responder -> requester, high outside IDLE
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                  READ;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  READY;
    logic                  ERR;
    logic                  BUSY;

    modport master (
        output READ, WRITE, ADDR, DATA_IN,
        input  DATA_OUT, READY, ERR, BUSY
    );

    modport slave (
        input  READ, WRITE, ADDR, DATA_IN,
        output DATA_OUT, READY, ERR, BUSY
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with READY/ERR completion pulses
//
// Purpose: accepts one level-held READ or WRITE request, waits WAIT_STATES extra
// cycles, performs the access on a word-addressed array of 2^MEM_AW words, and
// pulses READY (with ERR for conflicting or out-of-range requests). A held request
// is parked in RELEASE so it is never serviced twice.
// Ports:
//   CLK   clock, all state changes on posedge
//   RST   asynchronous active-low reset
//   bus   mem_responder_if.slave: READ, WRITE, ADDR, DATA_IN in;
//         DATA_OUT, READY, ERR, BUSY out (all outputs registered)
module mem_responder #(
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_AW      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic           CLK,
    input  logic           RST,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  busy_q;

    // Storage is deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

    logic                  req_any;
    logic                  req_one;
    logic                  req_both;

    // Access port: driven from the live inputs when WAIT_STATES=0 accepts and
    // completes on the same edge, otherwise from the latched copies.
    logic                  acc_en;
    logic                  acc_op_wr;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_in_range;
    logic                  mem_we;

    assign req_any  = bus.READ | bus.WRITE;
    assign req_one  = bus.READ ^ bus.WRITE;
    assign req_both = bus.READ & bus.WRITE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        acc_en    = 1'b0;
        acc_op_wr = op_wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_one) begin
                    op_wr_d = bus.WRITE;
                    addr_d  = bus.ADDR;
                    wdata_d = bus.DATA_IN;
                    cnt_d   = WS;
                    if (WAIT_STATES == 0) begin
                        acc_en    = 1'b1;
                        acc_op_wr = bus.WRITE;
                        acc_addr  = bus.ADDR;
                        acc_wdata = bus.DATA_IN;
                        ready_d   = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_WAIT;
                    end
                end else if (req_both) begin
                    // Conflicting request: report it, touch nothing.
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (!req_any) begin
                    // Requester withdrew: abandon silently.
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    acc_en  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = req_any ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                if (!req_any) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any address bit above the array index means the word does not exist.
        acc_in_range = ((acc_addr >> MEM_AW) == '0);

        if (acc_en) begin
            if (!acc_in_range) begin
                err_d = 1'b1;
                if (!acc_op_wr) begin
                    rdata_d = '0;
                end
            end else if (!acc_op_wr) begin
                rdata_d = mem[acc_addr[MEM_AW-1:0]];
            end
        end
    end

    // RST gating keeps a write from landing on an edge where reset is held.
    assign mem_we = RST & acc_en & acc_op_wr & acc_in_range;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[acc_addr[MEM_AW-1:0]] <= acc_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign bus.DATA_OUT = rdata_q;
    assign bus.READY    = ready_q;
    assign bus.ERR      = err_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic CLK;
    logic rst2;
    logic rst0;
    int   vectors;
    int   miscompares;

    mem_responder_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus2 ();
    mem_responder_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus0 ();

    mem_responder #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .MEM_AW(8), .WAIT_STATES(2)) dut2 (
        .CLK (CLK),
        .RST (rst2),
        .bus (bus2)
    );

    mem_responder #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .MEM_AW(8), .WAIT_STATES(0)) dut0 (
        .CLK (CLK),
        .RST (rst0),
        .bus (bus0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue2(input logic rd, input logic wr, input logic [25:0] a, input logic [31:0] d);
        bus2.READ    = rd;
        bus2.WRITE   = wr;
        bus2.ADDR    = a;
        bus2.DATA_IN = d;
    endtask

    // Ticks counted from issuing until READY is seen; the first tick is the
    // accepting edge, so a latency of L cycles after acceptance reads as L+1.
    task automatic wait_rdy2(input string tag, input int exp_ticks);
        int n;
        n = 0;
        while (bus2.READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(exp_ticks));
    endtask

    task automatic wait_rdy0(input string tag, input int exp_ticks);
        int n;
        n = 0;
        while (bus0.READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(exp_ticks));
    endtask

    initial begin
        int pulses;
        logic busy_all;

        vectors     = 0;
        miscompares = 0;
        rst2 = 1'b0;
        rst0 = 1'b0;
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        bus0.READ    = 1'b0;
        bus0.WRITE   = 1'b0;
        bus0.ADDR    = 26'h0;
        bus0.DATA_IN = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 64'(bus2.READY), 64'h0);
        chk("rst_err", 64'(bus2.ERR), 64'h0);
        chk("rst_busy", 64'(bus2.BUSY), 64'h0);
        chk("rst_dout", 64'(bus2.DATA_OUT), 64'h0);
        rst2 = 1'b1;
        tick();
        chk("post_rst_busy", 64'(bus2.BUSY), 64'h0);

        // Write 0x05 <- DEADBEEF, held past READY; READY 3 cycles after acceptance
        issue2(1'b0, 1'b1, 26'h05, 32'hDEADBEEF);
        tick();
        chk("wr_busy_rise", 64'(bus2.BUSY), 64'h1);
        chk("wr_no_early_ready", 64'(bus2.READY), 64'h0);
        wait_rdy2("wr_latency", 3);
        chk("wr_err", 64'(bus2.ERR), 64'h0);
        tick();
        chk("wr_pulse_end", 64'(bus2.READY), 64'h0);
        chk("wr_release_busy", 64'(bus2.BUSY), 64'h1);
        tick();
        chk("wr_release_hold", 64'(bus2.BUSY), 64'h1);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        chk("wr_release_exit", 64'(bus2.BUSY), 64'h0);

        // Read 0x05 back, then keep READ held: no second pulse, BUSY stays up
        issue2(1'b1, 1'b0, 26'h05, 32'h0);
        wait_rdy2("rd_latency", 4);
        chk("rd_data", 64'(bus2.DATA_OUT), 64'hDEADBEEF);
        chk("rd_err", 64'(bus2.ERR), 64'h0);
        pulses   = 0;
        busy_all = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus2.READY === 1'b1) pulses++;
            busy_all = busy_all & bus2.BUSY;
        end
        chk("held_no_repeat", 64'(pulses), 64'h0);
        chk("held_busy", 64'(busy_all), 64'h1);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        chk("held_busy_fall", 64'(bus2.BUSY), 64'h0);

        // Known value at 0x00
        issue2(1'b0, 1'b1, 26'h00, 32'h11111111);
        wait_rdy2("wr0_latency", 4);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();

        // Conflict: READY and ERR on the edge after acceptance, DATA_OUT untouched
        issue2(1'b1, 1'b1, 26'h00, 32'h0);
        wait_rdy2("conflict_latency", 1);
        chk("conflict_err", 64'(bus2.ERR), 64'h1);
        chk("conflict_dout", 64'(bus2.DATA_OUT), 64'hDEADBEEF);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        chk("conflict_err_clear", 64'(bus2.ERR), 64'h0);

        // Out-of-range write to 0x100 must not alias onto 0x00
        issue2(1'b0, 1'b1, 26'h100, 32'h00000BAD);
        wait_rdy2("oob_wr_latency", 4);
        chk("oob_wr_err", 64'(bus2.ERR), 64'h1);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        issue2(1'b1, 1'b0, 26'h00, 32'h0);
        wait_rdy2("rd0_latency", 4);
        chk("rd0_unchanged", 64'(bus2.DATA_OUT), 64'h11111111);
        chk("rd0_err", 64'(bus2.ERR), 64'h0);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        issue2(1'b1, 1'b0, 26'h100, 32'h0);
        wait_rdy2("oob_rd_latency", 4);
        chk("oob_rd_zero", 64'(bus2.DATA_OUT), 64'h0);
        chk("oob_rd_err", 64'(bus2.ERR), 64'h1);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();

        // Abort: read 0x00 accepted, dropped after one WAIT cycle
        issue2(1'b1, 1'b0, 26'h05, 32'h0);
        wait_rdy2("pre_abort_rd", 4);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        issue2(1'b1, 1'b0, 26'h00, 32'h0);
        tick();
        tick();
        chk("abort_busy_before", 64'(bus2.BUSY), 64'h1);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        chk("abort_busy", 64'(bus2.BUSY), 64'h0);
        chk("abort_ready", 64'(bus2.READY), 64'h0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus2.READY === 1'b1) pulses++;
        end
        chk("abort_no_ready", 64'(pulses), 64'h0);
        chk("abort_dout", 64'(bus2.DATA_OUT), 64'hDEADBEEF);

        // Reset during a pending write keeps the old contents of 0x07
        issue2(1'b0, 1'b1, 26'h07, 32'hAAAA0007);
        wait_rdy2("old7_latency", 4);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        issue2(1'b0, 1'b1, 26'h07, 32'h12345678);
        tick();
        tick();
        rst2 = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus2.BUSY), 64'h0);
        chk("midrst_ready", 64'(bus2.READY), 64'h0);
        chk("midrst_dout", 64'(bus2.DATA_OUT), 64'h0);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();
        rst2 = 1'b1;
        tick();
        issue2(1'b1, 1'b0, 26'h07, 32'h0);
        wait_rdy2("rd7_latency", 4);
        chk("rd7_old", 64'(bus2.DATA_OUT), 64'hAAAA0007);
        issue2(1'b0, 1'b0, 26'h0, 32'h0);
        tick();

        // WAIT_STATES=0: READY on the edge after acceptance
        rst0 = 1'b1;
        tick();
        bus0.WRITE   = 1'b1;
        bus0.ADDR    = 26'h09;
        bus0.DATA_IN = 32'hCAFEF00D;
        wait_rdy0("ws0_wr_latency", 1);
        chk("ws0_wr_err", 64'(bus0.ERR), 64'h0);
        bus0.WRITE = 1'b0;
        tick();
        chk("ws0_idle", 64'(bus0.BUSY), 64'h0);
        bus0.READ = 1'b1;
        wait_rdy0("ws0_rd_latency", 1);
        chk("ws0_rd_data", 64'(bus0.DATA_OUT), 64'hCAFEF00D);
        bus0.READ = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
